// File: rtl/rptr_empty_fwft.sv
// rptr_empty_fwft
// Read-side pointer and empty-flag controller for an asynchronous FIFO, with a
// first-word-fall-through output stage. Everything here runs on rclk.
//
// Ports:
//   rclk, rrst    read clock and synchronous active-high reset
//   rq2_wptr      Gray write pointer, already synchronised into rclk
//   rdata_mem     memory read data, valid the cycle after ren
//   raddr, ren    memory read address and read strobe
//   rptr          registered Gray read pointer for the write domain
//   rempty        registered pointer-empty flag
//   dout, dout_valid, dout_ready
//                 head of the 2-entry output buffer and its handshake
//   raempty       almost-empty flag
//
// Optional feature: define RPTR_ALMOST_EMPTY_EN to build a real almost-empty
// flag (level <= AEMPTY_THRESH). Without it, raempty simply mirrors rempty.
module rptr_empty_fwft #(
  parameter int ADDRSIZE      = 4,
  parameter int DATASIZE      = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                raempty
);

  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic                rempty_q, rempty_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          buf_count_q, buf_count_d;
  logic [DATASIZE-1:0] buf0_q, buf0_d;
  logic [DATASIZE-1:0] buf1_q, buf1_d;
  logic [1:0]          occ;
  logic                pop;

  // Fetch credit and pointer advance. Words already buffered plus the one in
  // flight from memory may never exceed two, unless a pop frees a slot this
  // cycle. ren therefore depends only on registered state and dout_ready.
  always_comb begin
    occ        = buf_count_q + {1'b0, inflight_q};
    pop        = (buf_count_q != 2'd0) & dout_ready;
    ren        = ~rempty_q & ((occ < 2'd2) | pop);
    rbin_d     = rbin_q + {{ADDRSIZE{1'b0}}, ren};
    rptr_d     = (rbin_d >> 1) ^ rbin_d;
    rempty_d   = (rptr_d == rq2_wptr);
    inflight_d = ren;
  end

  // Output buffer: buf0 is always the head. A word requested last cycle lands
  // at the tail; a simultaneous pop shifts buf1 forward so order is kept.
  always_comb begin
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    buf_count_d = buf_count_q;
    case ({inflight_q, pop})
      2'b01: begin
        buf0_d      = buf1_q;
        buf_count_d = buf_count_q - 2'd1;
      end
      2'b10: begin
        if (buf_count_q == 2'd0) buf0_d = rdata_mem;
        else                     buf1_d = rdata_mem;
        buf_count_d = buf_count_q + 2'd1;
      end
      2'b11: begin
        if (buf_count_q == 2'd1) begin
          buf0_d = rdata_mem;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rdata_mem;
        end
      end
      default: ;
    endcase
  end

  // Clearing inflight on reset drops any memory word still returning.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q      <= '0;
      rptr_q      <= '0;
      rempty_q    <= 1'b1;
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_q      <= rptr_d;
      rempty_q    <= rempty_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign dout_valid = (buf_count_q != 2'd0);
  assign dout       = dout_valid ? buf0_q : '0;

`ifdef RPTR_ALMOST_EMPTY_EN
  localparam logic [ADDRSIZE:0] AE_THRESH = (ADDRSIZE + 1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] rlevel;
  logic              raempty_q, raempty_d;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  // The level uses rbin_d so the flag lines up with rempty's timing.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
    rlevel    = wbin_s - rbin_d;
    raempty_d = (rlevel <= AE_THRESH);
  end

  always_ff @(posedge rclk) begin
    if (rrst) raempty_q <= 1'b1;
    else      raempty_q <= raempty_d;
  end

  assign raempty = raempty_q;
`else
  assign raempty = rempty_q;
`endif

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Self-checking bench for rptr_empty_fwft. A behavioural model tracks the FIFO
// as word counts and a queue of expected output words; a small memory model
// answers the DUT's read requests one cycle later.
module tb_rptr_empty_fwft;

  localparam int ADDRSIZE      = 4;
  localparam int DATASIZE      = 8;
  localparam int AEMPTY_THRESH = 2;
  localparam int DEPTH         = 1 << ADDRSIZE;

  logic                rclk = 1'b0;
  logic                rrst = 1'b1;
  logic [ADDRSIZE:0]   rq2_wptr = '0;
  logic [DATASIZE-1:0] rdata_mem = '0;
  logic [ADDRSIZE-1:0] raddr;
  logic                ren;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready = 1'b0;
  logic                raempty;

  rptr_empty_fwft #(
    .ADDRSIZE(ADDRSIZE), .DATASIZE(DATASIZE), .AEMPTY_THRESH(AEMPTY_THRESH)
  ) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rdata_mem(rdata_mem),
    .raddr(raddr), .ren(ren), .rptr(rptr), .rempty(rempty), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .raempty(raempty)
  );

  always #5 rclk = ~rclk;

  int assertCount = 0;
  int failCount   = 0;

  // Writer side and memory model
  logic [DATASIZE-1:0] memArr [0:DEPTH-1];
  logic [DATASIZE-1:0] wlog   [0:4095];
  int   wcnt = 0;
  logic memReqValid = 1'b0;
  logic [ADDRSIZE-1:0] memReqAddr = '0;

  // Reference model state
  bit   modelValid = 1'b0;
  int   rcnt = 0;
  bit   emptyReg = 1'b1;
  bit   aemptyReg = 1'b1;
  bit   pending = 1'b0;
  int   pendIdx = 0;
  logic [DATASIZE-1:0] outQ [$];

  // Observations
  int   dutOcc = 0;
  int   renPulses = 0;
  int   popCount = 0;
  bit   recordRen = 1'b0;
  logic [ADDRSIZE-1:0] raddrLog [$];
  logic sRen, sDv, sRempty;
  logic [DATASIZE-1:0] sDout;
  logic [ADDRSIZE:0] sRptr;

  function automatic logic [ADDRSIZE:0] toGray(input int n);
    logic [ADDRSIZE:0] b;
    b = n[ADDRSIZE:0];
    return (b >> 1) ^ b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One read-clock cycle: drive inputs, compare against the model, advance it.
  task automatic applyStimulus(input bit doReset, input int writes, input bit ready);
    int occE;
    bit popE, renE, dvE;
    logic [DATASIZE-1:0] doutE, d;
    @(negedge rclk);
    if (memReqValid === 1'b1) rdata_mem = memArr[memReqAddr];
    else                      rdata_mem = DATASIZE'($urandom);
    rrst       = doReset;
    dout_ready = ready;
    if (doReset) begin
      wcnt = 0;
    end else begin
      for (int k = 0; k < writes; k++) begin
        if (wcnt - rcnt < DEPTH) begin
          d = DATASIZE'($urandom);
          memArr[wcnt % DEPTH] = d;
          wlog[wcnt % 4096]    = d;
          wcnt++;
        end
      end
    end
    rq2_wptr = toGray(wcnt);
    #1;
    sRen = ren; sDv = dout_valid; sDout = dout; sRptr = rptr; sRempty = rempty;

    dvE   = (outQ.size() != 0);
    doutE = dvE ? outQ[0] : '0;
    occE  = outQ.size() + int'(pending);
    popE  = dvE && ready;
    renE  = !emptyReg && (occE < 2 || popE);

    if (modelValid) begin
      checkOutput("rempty",     32'(rempty),     32'(emptyReg));
      checkOutput("ren",        32'(ren),        32'(renE));
      checkOutput("raddr",      32'(raddr),      32'(rcnt % DEPTH));
      checkOutput("rptr",       32'(rptr),       32'(toGray(rcnt)));
      checkOutput("dout_valid", 32'(dout_valid), 32'(dvE));
      checkOutput("dout",       32'(dout),       32'(doutE));
      checkOutput("raempty",    32'(raempty),    32'(aemptyReg));
    end

    memReqValid = (ren === 1'b1);
    memReqAddr  = raddr;
    if (ren === 1'b1) renPulses++;
    if (dout_valid === 1'b1 && ready) popCount++;
    if (recordRen && ren === 1'b1) raddrLog.push_back(raddr);

    if (doReset) begin
      modelValid = 1'b1;
      rcnt = 0; emptyReg = 1'b1; aemptyReg = 1'b1; pending = 1'b0;
      outQ.delete();
      dutOcc = 0;
    end else if (modelValid) begin
      dutOcc = dutOcc + int'(ren === 1'b1) - int'(dout_valid === 1'b1 && ready);
      checkOutput("no_overflow", 32'(dutOcc <= 2), 32'd1);
      if (popE) void'(outQ.pop_front());
      if (pending) outQ.push_back(wlog[pendIdx % 4096]);
      pending = renE;
      pendIdx = rcnt;
      rcnt    = rcnt + int'(renE);
      emptyReg = (rcnt == wcnt);
`ifdef RPTR_ALMOST_EMPTY_EN
      aemptyReg = ((wcnt - rcnt) <= AEMPTY_THRESH);
`else
      aemptyReg = emptyReg;
`endif
    end
    @(posedge rclk);
  endtask

  initial begin
    int lat;
    $display("[TB] start");
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("rst_rempty", 32'(sRempty), 32'd1);

    // First-word latency: one word into an empty FIFO
    applyStimulus(0, 0, 1);
    renPulses = 0;
    applyStimulus(0, 1, 1);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 1);
      lat++;
      if (sDv === 1'b1) break;
    end
    checkOutput("first_word_latency", 32'(lat), 32'd3);
    checkOutput("first_word_data", 32'(sDout), 32'(wlog[0]));
    checkOutput("first_word_ren_pulses", 32'(renPulses), 32'd1);

    // Reset mid-stream while a read is outstanding
    applyStimulus(1, 0, 0);
    applyStimulus(0, 3, 0);
    applyStimulus(0, 0, 0);
    checkOutput("midrst_ren_before", 32'(sRen), 32'd1);
    applyStimulus(1, 0, 0);
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 1);
    checkOutput("midrst_rempty", 32'(sRempty), 32'd1);
    checkOutput("midrst_dv", 32'(sDv), 32'd0);
    checkOutput("midrst_rptr", 32'(sRptr), 32'd0);

    // Backpressure: 8 words, consumer stalled for 10 cycles
    applyStimulus(1, 0, 0);
    renPulses = 0;
    applyStimulus(0, 8, 0);
    for (int c = 0; c < 9; c++) applyStimulus(0, 0, 0);
    checkOutput("bp_ren_pulses", 32'(renPulses), 32'd2);
    checkOutput("bp_dv", 32'(sDv), 32'd1);
    checkOutput("bp_hold", 32'(sDout), 32'(wlog[0]));
    popCount = 0;
    for (int c = 0; c < 8; c++) applyStimulus(0, 0, 1);
    checkOutput("bp_drain_rate", 32'(popCount), 32'd8);
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 1);

    // Wrap-around: 40 words streamed through a 16-deep FIFO
    applyStimulus(1, 0, 0);
    raddrLog.delete();
    recordRen = 1'b1;
    for (int c = 0; c < 60; c++) applyStimulus(0, (wcnt < 40) ? 1 : 0, 1);
    recordRen = 1'b0;
    checkOutput("wrap_ren_count", 32'(raddrLog.size()), 32'd40);
    lat = 0;
    foreach (raddrLog[i]) if (raddrLog[i] != ADDRSIZE'(i % DEPTH)) lat++;
    checkOutput("wrap_raddr_seq", 32'(lat), 32'd0);

    // Empty boundary: exactly one word beyond the read pointer
    renPulses = 0;
    applyStimulus(0, 1, 1);
    for (int c = 0; c < 6; c++) applyStimulus(0, 0, 1);
    checkOutput("boundary_ren_pulses", 32'(renPulses), 32'd1);
    checkOutput("boundary_rempty", 32'(sRempty), 32'd1);

    // Almost-empty: level 5 with the consumer draining
    applyStimulus(1, 0, 0);
    applyStimulus(0, 5, 0);
    for (int c = 0; c < 12; c++) applyStimulus(0, 0, 1);

    // Randomised traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(($urandom_range(0, 199) == 0), int'($urandom_range(0, 2)) - 1 + int'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
